// File: rtl/carry_skip_adder_8b.sv
// carry_skip_adder_8b
// Registered 8-bit carry-skip adder: {Cout,Sum} = A + B + Cin, one cycle latency.
// The core is two 4-bit ripple blocks. Each block has a skip multiplexer on its
// carry-out, steered by the block propagate signal. The result feeds one register stage.
module carry_skip_adder_8b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout,
  output logic       out_valid
);

  localparam int BLK_W = 4;

  // Bitwise propagate / generate terms for all eight bit positions.
  logic [7:0]     p;
  logic [7:0]     g;

  // Ripple carry chains, one per block.
  // Index 0 is the block carry-in. Index BLK_W is the rippled carry-out.
  logic [BLK_W:0] rc0;
  logic [BLK_W:0] rc1;

  // Block propagate flags.
  logic           blk_p0;
  logic           blk_p1;

  // Skip-mux outputs.
  // c4 is the carry into block 1. c8 is the final carry-out.
  logic           c4;
  logic           c8;

  // Combinational sum ahead of the output register.
  logic [7:0]     sum_d;

  assign p = A ^ B;
  assign g = A & B;

  // Block 0: ripple the carry through bits [3:0], starting from Cin.
  always_comb begin
    // NOTE: every bit gets a default before the loop, so no path can leave a bit unassigned and infer a latch.
    rc0    = '0;
    rc0[0] = Cin;
    for (int i = 0; i < BLK_W; i++) begin
      rc0[i+1] = g[i] | (p[i] & rc0[i]);
    end
  end

  // When every bit of block 0 propagates, the block carry-in passes straight to c4.
  // Otherwise c4 takes the rippled carry.
  assign blk_p0 = &p[BLK_W-1:0];
  assign c4     = blk_p0 ? Cin : rc0[BLK_W];

  // Block 1: ripple the carry through bits [7:4], starting from the skip output c4.
  always_comb begin
    rc1    = '0;
    rc1[0] = c4;
    for (int i = 0; i < BLK_W; i++) begin
      rc1[i+1] = g[i+BLK_W] | (p[i+BLK_W] & rc1[i]);
    end
  end

  // Block 1 skip mux produces the final carry-out.
  // It is logically redundant with the ripple path; it is kept so the carry takes the short route.
  assign blk_p1 = &p[7:BLK_W];
  assign c8     = blk_p1 ? c4 : rc1[BLK_W];

  // Sum bit i is p[i] XOR the carry into bit i within its block.
  assign sum_d = {p[7:BLK_W] ^ rc1[BLK_W-1:0], p[BLK_W-1:0] ^ rc0[BLK_W-1:0]};

  // Result register: capture the sum on valid cycles and hold it otherwise.
  // Reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      Sum  <= 8'h00;
      Cout <= 1'b0;
    end else if (in_valid) begin
      Sum  <= sum_d;
      Cout <= c8;
    end
  end

  // Valid flag: follows in_valid with one cycle of latency.
  // NOTE: only the small output registers exist here, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_carry_skip_adder_8b.sv
// tb_carry_skip_adder_8b
// Self-checking bench for carry_skip_adder_8b. Directed corner cases come first,
// then randomized traffic compared against plain 9-bit arithmetic.
module tb_carry_skip_adder_8b;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] Sum;
  logic       Cout;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  carry_skip_adder_8b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sum       (Sum),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input set on the falling edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    @(negedge clk);
    A        = a;
    B        = b;
    Cin      = c;
    in_valid = v;
  endtask

  // Let the rising edge pass, then wait so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset holds outputs at zero with no clock edge. The first edge after release captures.
  task automatic test_reset();
    rst_n = 1'b0; A = 8'hFF; B = 8'hFF; Cin = 1'b1; in_valid = 1'b1;
    #2;
    checks++;
    if ({out_valid, Cout, Sum} !== 10'h000) begin
      errors++;
      $display("FAIL reset_async: got v=%b c=%b s=%h expected v=0 c=0 s=00", out_valid, Cout, Sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({out_valid, Cout, Sum} !== {1'b1, 9'h1FF}) begin
      errors++;
      $display("FAIL reset_first_capture: got v=%b c=%b s=%h expected v=1 c=1 s=FF", out_valid, Cout, Sum);
    end
  endtask

  // Directed adds, issued back to back. Each expected value is the arithmetic sum.
  task automatic test_directed();
    logic [7:0] ta [6] = '{8'h00, 8'h0F, 8'hF0, 8'h55, 8'hFF, 8'h80};
    logic [7:0] tb [6] = '{8'h00, 8'h01, 8'h0F, 8'hAA, 8'h01, 8'h80};
    logic       tc [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [8:0] req [6] = '{9'h000, 9'h010, 9'h100, 9'h0FF, 9'h101, 9'h100};
    for (int i = 0; i < 6; i++) begin
      drive(ta[i], tb[i], tc[i], 1'b1);
      step();
      checks++;
      if (out_valid !== 1'b1 || {Cout, Sum} !== req[i]) begin
        errors++;
        $display("FAIL directed_%0d (%h+%h+%b): got v=%b %h expected v=1 %h",
                 i, ta[i], tb[i], tc[i], out_valid, {Cout, Sum}, req[i]);
      end
    end
  endtask

  // Dropping in_valid holds the result and clears out_valid. Resuming has one cycle of latency.
  task automatic test_hold();
    drive(8'h3C, 8'h42, 1'b1, 1'b1);
    step();
    checks++;
    if ({out_valid, Cout, Sum} !== {1'b1, 9'h07F}) begin
      errors++;
      $display("FAIL hold_load: got v=%b %h expected v=1 07F", out_valid, {Cout, Sum});
    end
    for (int i = 0; i < 2; i++) begin
      drive(8'hE0 + 8'(i), 8'h77, 1'b1, 1'b0);
      step();
      checks++;
      if ({out_valid, Cout, Sum} !== {1'b0, 9'h07F}) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got v=%b %h expected v=0 07F", i, out_valid, {Cout, Sum});
      end
    end
    drive(8'hC8, 8'h64, 1'b0, 1'b1);
    step();
    checks++;
    if ({out_valid, Cout, Sum} !== {1'b1, 9'h12C}) begin
      errors++;
      $display("FAIL hold_resume: got v=%b %h expected v=1 12C", out_valid, {Cout, Sum});
    end
  endtask

  // Asserting reset mid-stream discards the in-flight add and clears the outputs between edges.
  task automatic test_midstream_reset();
    drive(8'h12, 8'h34, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, Cout, Sum} !== 10'h000) begin
      errors++;
      $display("FAIL midreset_async: got v=%b %h expected v=0 000", out_valid, {Cout, Sum});
    end
    step();
    checks++;
    if ({out_valid, Cout, Sum} !== 10'h000) begin
      errors++;
      $display("FAIL midreset_held: got v=%b %h expected v=0 000", out_valid, {Cout, Sum});
    end
    drive(8'h01, 8'h01, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    checks++;
    if ({out_valid, Cout, Sum} !== 10'h000) begin
      errors++;
      $display("FAIL midreset_release: got v=%b %h expected v=0 000", out_valid, {Cout, Sum});
    end
  endtask

  // Random traffic with random in_valid. The model keeps the last captured sum and the previous valid bit.
  task automatic test_random();
    logic [8:0] exp_res   = 9'h000;
    logic       exp_valid = 1'b0;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       v;
    for (int n = 0; n < 12000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      v = ($urandom_range(0, 3) != 0);
      drive(a, b, c, v);
      step();
      if (v) exp_res = 9'(a) + 9'(b) + 9'(c);
      exp_valid = v;
      checks++;
      if (out_valid !== exp_valid || {Cout, Sum} !== exp_res) begin
        errors++;
        $display("FAIL random_%0d (%h+%h+%b v=%b): got v=%b %h expected v=%b %h",
                 n, a, b, c, v, out_valid, {Cout, Sum}, exp_valid, exp_res);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_midstream_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
